synchronous_fifo: RTL and testbench

- Single-clock first-in/first-out buffer with parameterised data width and depth.
- Writes and reads are independent, and both may occur in the same cycle.
- Provides full and empty status flags; writes when full and reads when empty are ignored.
- Used as a general-purpose rate/latency decoupling buffer between two producers/consumers in the same clock domain.

---
 rtl/synchronous_fifo_if.sv | 31 +++
 rtl/synchronous_fifo.sv | 69 ++++++
 tb/tb_synchronous_fifo.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/synchronous_fifo_if.sv
// Handshake/data bundle between a FIFO producer/consumer and the FIFO storage.
interface synchronous_fifo_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] d_in;
    logic             w_enb;
    logic             r_enb;
    logic [WIDTH-1:0] d_out;
    logic             full;
    logic             empty;

    // Side that drives write data and enables.
    modport master (
        output d_in,
        output w_enb,
        output r_enb,
        input  d_out,
        input  full,
        input  empty
    );

    // FIFO side.
    modport slave (
        input  d_in,
        input  w_enb,
        input  r_enb,
        output d_out,
        output full,
        output empty
    );
endinterface

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered read data and
// overflow/underflow protection.
module synchronous_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                clk,
    input  logic                reset,
    synchronous_fifo_if.slave   bus
);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
    logic [WIDTH-1:0]     d_out_q, d_out_d;
    logic                 full_c;
    logic                 empty_c;
    logic                 wr_ok_c;
    logic                 rd_ok_c;

    // Status flags from registered pointers; acceptance judged on pre-edge flags.
    always_comb begin
        empty_c = (wptr_q == rptr_q);
        full_c  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                  (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
        wr_ok_c = bus.w_enb && !full_c;
        rd_ok_c = bus.r_enb && !empty_c;
    end

    // Next-state for pointers and read data.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        d_out_d = d_out_q;
        if (wr_ok_c) begin
            wptr_d = wptr_q + PTR_WIDTH'(1);
        end
        if (rd_ok_c) begin
            rptr_d  = rptr_q + PTR_WIDTH'(1);
            d_out_d = mem_q[rptr_q[ADDR_WIDTH-1:0]];
        end
    end

    // Pointer and read-data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            d_out_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            d_out_q <= d_out_d;
        end
    end

    // Storage write; contents survive reset, reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok_c) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= bus.d_in;
        end
    end

    assign bus.d_out = d_out_q;
    assign bus.full  = full_c;
    assign bus.empty = empty_c;
endmodule

// File: tb/tb_synchronous_fifo.sv
// Directed bench for synchronous_fifo with a small depth so wrap and full are reachable.
module tb_synchronous_fifo;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;

    synchronous_fifo_if #(.WIDTH(WIDTH)) bus ();

    synchronous_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge with the given enables; outputs settle 1 time unit after the edge.
    task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
        bus.w_enb = w;
        bus.r_enb = r;
        bus.d_in  = d;
        @(posedge clk);
        #1;
        bus.w_enb = 1'b0;
        bus.r_enb = 1'b0;
        bus.d_in  = '0;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) cycle(1'b0, 1'b0, '0);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset(1);
        vec_cnt++;
        if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        vec_cnt++;
        if (bus.full !== 1'b0) begin err_cnt++; $display("FAIL reset_full got %b want 0", bus.full); end
        vec_cnt++;
        if (bus.d_out !== 32'h0) begin err_cnt++; $display("FAIL reset_dout got %h want 0", bus.d_out); end
    endtask

    task automatic test_underflow;
        cycle(1'b0, 1'b1, 32'h0);
        vec_cnt++;
        if (bus.d_out !== 32'h0) begin err_cnt++; $display("FAIL underflow_dout got %h want 0", bus.d_out); end
        vec_cnt++;
        if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL underflow_empty got %b want 1", bus.empty); end
        vec_cnt++;
        if (bus.full !== 1'b0) begin err_cnt++; $display("FAIL underflow_full got %b want 0", bus.full); end
    endtask

    task automatic test_basic;
        cycle(1'b1, 1'b0, 32'hAABBCCDD);
        vec_cnt++;
        if (bus.empty !== 1'b0) begin err_cnt++; $display("FAIL basic_not_empty got %b want 0", bus.empty); end
        vec_cnt++;
        if (bus.d_out !== 32'h0) begin err_cnt++; $display("FAIL basic_dout_pre got %h want 0", bus.d_out); end
        cycle(1'b0, 1'b1, 32'h0);
        vec_cnt++;
        if (bus.d_out !== 32'hAABBCCDD) begin err_cnt++; $display("FAIL basic_dout got %h want aabbccdd", bus.d_out); end
        vec_cnt++;
        if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL basic_empty got %b want 1", bus.empty); end
        cycle(1'b0, 1'b0, 32'h0);
        vec_cnt++;
        if (bus.d_out !== 32'hAABBCCDD) begin err_cnt++; $display("FAIL basic_hold got %h want aabbccdd", bus.d_out); end
    endtask

    task automatic test_full_overflow;
        logic [WIDTH-1:0] exp_q [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            exp_q[i] = $urandom() | 32'h1;
            if (exp_q[i] == 32'hDEADBEEF) exp_q[i] = 32'h1234_0001;
            cycle(1'b1, 1'b0, exp_q[i]);
        end
        vec_cnt++;
        if (bus.full !== 1'b1) begin err_cnt++; $display("FAIL full_flag got %b want 1", bus.full); end
        vec_cnt++;
        if (bus.empty !== 1'b0) begin err_cnt++; $display("FAIL full_not_empty got %b want 0", bus.empty); end
        cycle(1'b1, 1'b0, 32'hDEADBEEF);
        vec_cnt++;
        if (bus.full !== 1'b1) begin err_cnt++; $display("FAIL overflow_full got %b want 1", bus.full); end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 32'h0);
            vec_cnt++;
            if (bus.d_out !== exp_q[i]) begin err_cnt++; $display("FAIL overflow_read[%0d] got %h want %h", i, bus.d_out, exp_q[i]); end
            vec_cnt++;
            if (bus.full !== 1'b0) begin err_cnt++; $display("FAIL overflow_full_drop[%0d] got %b want 0", i, bus.full); end
        end
        vec_cnt++;
        if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL overflow_drained got %b want 1", bus.empty); end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, WIDTH'(i));
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 32'h0);
            vec_cnt++;
            if (bus.d_out !== WIDTH'(i)) begin err_cnt++; $display("FAIL wrap_read[%0d] got %h want %h", i, bus.d_out, WIDTH'(i)); end
        end
        vec_cnt++;
        if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL wrap_empty got %b want 1", bus.empty); end
        cycle(1'b1, 1'b0, 32'h5A5A5A5A);
        cycle(1'b0, 1'b1, 32'h0);
        vec_cnt++;
        if (bus.d_out !== 32'h5A5A5A5A) begin err_cnt++; $display("FAIL wrap_5a got %h want 5a5a5a5a", bus.d_out); end
        vec_cnt++;
        if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL wrap_5a_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_simultaneous;
        logic [WIDTH-1:0] v;
        cycle(1'b1, 1'b0, 32'h55555555);
        cycle(1'b1, 1'b1, 32'hAAAAAAAA);
        vec_cnt++;
        if (bus.d_out !== 32'h55555555) begin err_cnt++; $display("FAIL simul_dout got %h want 55555555", bus.d_out); end
        vec_cnt++;
        if (bus.empty !== 1'b0) begin err_cnt++; $display("FAIL simul_count1 empty got %b want 0", bus.empty); end
        cycle(1'b0, 1'b1, 32'h0);
        vec_cnt++;
        if (bus.d_out !== 32'hAAAAAAAA) begin err_cnt++; $display("FAIL simul_second got %h want aaaaaaaa", bus.d_out); end
        vec_cnt++;
        if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL simul_empty got %b want 1", bus.empty); end
        // Both enables while empty: write only, no read-through.
        cycle(1'b1, 1'b1, 32'h11111111);
        vec_cnt++;
        if (bus.d_out !== 32'hAAAAAAAA) begin err_cnt++; $display("FAIL simul_empty_hold got %h want aaaaaaaa", bus.d_out); end
        vec_cnt++;
        if (bus.empty !== 1'b0) begin err_cnt++; $display("FAIL simul_empty_wr got %b want 0", bus.empty); end
        cycle(1'b0, 1'b1, 32'h0);
        vec_cnt++;
        if (bus.d_out !== 32'h11111111) begin err_cnt++; $display("FAIL simul_empty_rd got %h want 11111111", bus.d_out); end
        // Both enables while full: read only, write dropped.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 32'hC000_0000 + WIDTH'(i));
        cycle(1'b1, 1'b1, 32'hFFFF0000);
        vec_cnt++;
        if (bus.d_out !== 32'hC0000000) begin err_cnt++; $display("FAIL simul_full_rd got %h want c0000000", bus.d_out); end
        vec_cnt++;
        if (bus.full !== 1'b0) begin err_cnt++; $display("FAIL simul_full_flag got %b want 0", bus.full); end
        for (int i = 1; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 32'h0);
            v = 32'hC000_0000 + WIDTH'(i);
            vec_cnt++;
            if (bus.d_out !== v) begin err_cnt++; $display("FAIL simul_full_drain[%0d] got %h want %h", i, bus.d_out, v); end
        end
        vec_cnt++;
        if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL simul_full_dropped empty got %b want 1", bus.empty); end
    endtask

    task automatic test_reset_mid;
        cycle(1'b1, 1'b0, 32'h12345678);
        reset = 1'b1;
        cycle(1'b1, 1'b1, 32'h87654321);
        cycle(1'b0, 1'b1, 32'h0);
        reset = 1'b0;
        vec_cnt++;
        if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL rstmid_empty got %b want 1", bus.empty); end
        vec_cnt++;
        if (bus.full !== 1'b0) begin err_cnt++; $display("FAIL rstmid_full got %b want 0", bus.full); end
        vec_cnt++;
        if (bus.d_out !== 32'h0) begin err_cnt++; $display("FAIL rstmid_dout got %h want 0", bus.d_out); end
        cycle(1'b0, 1'b1, 32'h0);
        vec_cnt++;
        if (bus.d_out !== 32'h0) begin err_cnt++; $display("FAIL rstmid_read got %h want 0", bus.d_out); end
        vec_cnt++;
        if (bus.empty !== 1'b1) begin err_cnt++; $display("FAIL rstmid_read_empty got %b want 1", bus.empty); end
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        reset     = 1'b1;
        bus.w_enb = 1'b0;
        bus.r_enb = 1'b0;
        bus.d_in  = '0;
        test_reset();
        test_underflow();
        test_basic();
        test_full_overflow();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
